// File: rtl/life_scheduler_if.sv
// Seeder, stepper and arena port-B signals owned by the life scheduler.
// master = scheduler side, slave = client/arena side.
interface life_scheduler_if #(
  parameter int ARENA_WIDTH = 48,
  parameter int ROW_BITS    = 10
);
  logic                   seed_start;
  logic                   seed_ready;
  logic [ROW_BITS-1:0]    seed_row;
  logic [ARENA_WIDTH-1:0] seed_cols;
  logic                   seed_write;

  logic                   step_start;
  logic                   step_ready;
  logic [ROW_BITS-1:0]    step_row;
  logic [ARENA_WIDTH-1:0] step_cols;
  logic                   step_write;

  logic [ROW_BITS-1:0]    arena_row;
  logic [ARENA_WIDTH-1:0] arena_cols;
  logic                   arena_write;

  modport master (
    output seed_start, step_start, arena_row, arena_cols, arena_write,
    input  seed_ready, seed_row, seed_cols, seed_write,
    input  step_ready, step_row, step_cols, step_write
  );

  modport slave (
    input  seed_start, step_start, arena_row, arena_cols, arena_write,
    output seed_ready, seed_row, seed_cols, seed_write,
    output step_ready, step_row, step_cols, step_write
  );
endinterface

// File: rtl/life_scheduler.sv
// Arbitrates arena port B between the seeder and the generation stepper:
// one seeding pass on request, then paced free-running generation steps.
module life_scheduler #(
  parameter int ARENA_WIDTH = 48,
  parameter int ROW_BITS    = 10,
  parameter int PERIOD_BITS = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   seed_req,
  input  logic                   run,
  input  logic [PERIOD_BITS-1:0] step_period,
  output logic                   busy,
  output logic [31:0]            generation,
  life_scheduler_if.master       bus
);

  typedef enum logic [2:0] {
    IDLE, SEED_GO, SEED_ARM, SEED_WAIT, PACE, STEP_GO, STEP_ARM, STEP_WAIT
  } state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_SEED, OWN_STEP} owner_t;

  state_t                 state_reg, state_next;
  owner_t                 owner_reg, owner_next;
  logic                   seed_pending_reg, seed_pending_next;
  logic                   seeded_reg, seeded_next;
  logic [PERIOD_BITS-1:0] pace_reg, pace_next;
  logic [31:0]            generation_reg, generation_next;
  logic [PERIOD_BITS-1:0] pace_last;

  // A zero period behaves like a period of one.
  assign pace_last = (step_period == '0) ? '0 : step_period - PERIOD_BITS'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      owner_reg        <= OWN_NONE;
      seed_pending_reg <= 1'b0;
      seeded_reg       <= 1'b0;
      pace_reg         <= '0;
      generation_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      owner_reg        <= owner_next;
      seed_pending_reg <= seed_pending_next;
      seeded_reg       <= seeded_next;
      pace_reg         <= pace_next;
      generation_reg   <= generation_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    seeded_next     = seeded_reg;
    pace_next       = pace_reg;
    generation_next = generation_reg;

    case (state_reg)
      IDLE: begin
        if (seed_pending_reg)
          state_next = SEED_GO;
        else if (run && (generation_reg != 32'd0 || seeded_reg))
          state_next = PACE;
      end
      SEED_GO: begin
        owner_next = OWN_SEED;
        state_next = SEED_ARM;
      end
      // The client may still report ready in the cycle it sees start.
      SEED_ARM: state_next = SEED_WAIT;
      SEED_WAIT: begin
        if (bus.seed_ready) begin
          owner_next      = OWN_NONE;
          generation_next = '0;
          seeded_next     = 1'b1;
          state_next      = IDLE;
        end
      end
      PACE: begin
        if (seed_pending_reg) begin
          pace_next  = '0;
          state_next = SEED_GO;
        end else if (!run) begin
          pace_next  = '0;
          state_next = IDLE;
        end else if (pace_reg >= pace_last) begin
          pace_next  = '0;
          state_next = STEP_GO;
        end else begin
          pace_next = pace_reg + PERIOD_BITS'(1);
        end
      end
      STEP_GO: begin
        owner_next = OWN_STEP;
        state_next = STEP_ARM;
      end
      STEP_ARM: state_next = STEP_WAIT;
      STEP_WAIT: begin
        if (bus.step_ready) begin
          owner_next      = OWN_NONE;
          generation_next = generation_reg + 32'd1;
          pace_next       = '0;
          if (seed_pending_reg)
            state_next = SEED_GO;
          else if (run)
            state_next = PACE;
          else
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A request arriving as SEED_GO is entered is kept rather than lost.
    seed_pending_next = seed_pending_reg;
    if (state_next == SEED_GO && state_reg != SEED_GO)
      seed_pending_next = 1'b0;
    if (seed_req)
      seed_pending_next = 1'b1;
  end

  always_comb begin
    bus.arena_row   = '0;
    bus.arena_cols  = '0;
    bus.arena_write = 1'b0;
    case (owner_reg)
      OWN_SEED: begin
        bus.arena_row   = bus.seed_row;
        bus.arena_cols  = bus.seed_cols;
        bus.arena_write = bus.seed_write;
      end
      OWN_STEP: begin
        bus.arena_row   = bus.step_row;
        bus.arena_cols  = bus.step_cols;
        bus.arena_write = bus.step_write;
      end
      default: ;
    endcase
  end

  assign bus.seed_start = (state_reg == SEED_GO);
  assign bus.step_start = (state_reg == STEP_GO);
  assign busy           = (state_reg != IDLE);
  assign generation     = generation_reg;

endmodule

// File: tb/tb_life_scheduler.sv
// Directed bench for life_scheduler with behavioural seeder, stepper and
// a 16-row arena model.
module tb_life_scheduler;
  localparam int AW        = 48;
  localparam int RB        = 10;
  localparam int PB        = 24;
  localparam int SEED_BUSY = 480;
  localparam int STEP_BUSY = 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          seed_req;
  logic          run;
  logic [PB-1:0] step_period;
  logic          busy;
  logic [31:0]   generation;
  logic          rogue;

  life_scheduler_if #(.ARENA_WIDTH(AW), .ROW_BITS(RB)) bus ();

  life_scheduler #(.ARENA_WIDTH(AW), .ROW_BITS(RB), .PERIOD_BITS(PB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seed_req    (seed_req),
    .run         (run),
    .step_period (step_period),
    .busy        (busy),
    .generation  (generation),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] seed_pat(input int r);
    return {16'h5EED, 16'hC0DE, 12'h000, 4'(r)};
  endfunction

  function automatic logic [AW-1:0] step_pat(input int r);
    return {16'h57E9, 16'h0000, 12'hFFF, 4'(r)};
  endfunction

  // Seeder: 480 busy cycles, writes rows 0..15 in its first 16 busy cycles.
  int seed_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)               seed_cnt <= 0;
    else if (bus.seed_start)    seed_cnt <= SEED_BUSY;
    else if (seed_cnt != 0)     seed_cnt <= seed_cnt - 1;
  end
  assign bus.seed_ready = (seed_cnt == 0);
  assign bus.seed_write = (seed_cnt >= SEED_BUSY - 15);
  assign bus.seed_row   = RB'(SEED_BUSY - seed_cnt);
  assign bus.seed_cols  = seed_pat(SEED_BUSY - seed_cnt);

  // Stepper: 20 busy cycles; in rogue mode it strobes writes unconditionally.
  int step_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)               step_cnt <= 0;
    else if (bus.step_start)    step_cnt <= STEP_BUSY;
    else if (step_cnt != 0)     step_cnt <= step_cnt - 1;
  end
  assign bus.step_ready = (step_cnt == 0);
  assign bus.step_write = rogue ? 1'b1 : (step_cnt >= 5);
  assign bus.step_row   = rogue ? RB'(3) : RB'(step_cnt % 16);
  assign bus.step_cols  = rogue ? 48'hBAD0_BAD0_BAD0 : step_pat(step_cnt % 16);

  logic [AW-1:0] arena_mem [16];
  always @(posedge clk)
    if (bus.arena_write) arena_mem[bus.arena_row[3:0]] <= bus.arena_cols;

  int seed_start_cnt = 0;
  int step_start_cnt = 0;
  int own_viol       = 0;
  always @(posedge clk) begin
    if (bus.seed_start) seed_start_cnt <= seed_start_cnt + 1;
    if (bus.step_start) step_start_cnt <= step_start_cnt + 1;
    if ((seed_cnt != 0 && (bus.arena_write != bus.seed_write ||
         (bus.seed_write && (bus.arena_row != bus.seed_row || bus.arena_cols != bus.seed_cols)))) ||
        (step_cnt != 0 && bus.arena_write != bus.step_write))
      own_viol <= own_viol + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end else begin
      $display("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.seed_start;
      1:       return bus.step_start;
      default: return !busy;
    endcase
  endfunction

  // Bounded wait; reports whether the awaited condition was reached.
  task automatic wait_for(input string tag, input int sel, input int limit, output int n);
    n = 0;
    while (!sig(sel) && n < limit) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(sig(sel)), 64'd1);
  endtask

  task automatic check_arena(input string tag);
    for (int r = 0; r < 16; r++)
      check_eq($sformatf("%s_row%0d", tag, r), 64'(arena_mem[r]), 64'(seed_pat(r)));
  endtask

  // Pulses seed_req in IDLE and checks start latency, one pulse, clean pass.
  task automatic seed_pass(input string tag);
    int s0, n;
    s0 = seed_start_cnt;
    seed_req = 1'b1;
    tick();
    seed_req = 1'b0;
    wait_for({tag, "_start_seen"}, 0, 20, n);
    check_eq({tag, "_latency"}, 64'(n + 1), 64'd2);
    wait_for({tag, "_done"}, 2, SEED_BUSY + 50, n);
    check_eq({tag, "_one_start"}, 64'(seed_start_cnt - s0), 64'd1);
    check_eq({tag, "_gen"}, 64'(generation), 64'd0);
    check_eq({tag, "_owner"}, 64'(own_viol), 64'd0);
    check_arena(tag);
  endtask

  initial begin
    int n, st;
    reset_n = 1'b0; seed_req = 1'b0; run = 1'b0; step_period = PB'(5); rogue = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_gen", 64'(generation), 64'd0);
    check_eq("rst_seed_start", 64'(bus.seed_start), 64'd0);
    check_eq("rst_step_start", 64'(bus.step_start), 64'd0);
    check_eq("rst_arena_write", 64'(bus.arena_write), 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: single seed pass with run low
    seed_pass("seed1");
    st = step_start_cnt;
    repeat (10) tick();
    check_eq("seed1_idle_busy", 64'(busy), 64'd0);
    check_eq("seed1_no_step", 64'(step_start_cnt - st), 64'd0);

    // 2: paced stepping, period = GO + ARM + 20 busy + 5 pace
    run = 1'b1;
    wait_for("step_first", 1, 200, n);
    check_eq("step_first_gen", 64'(generation), 64'd0);
    for (int g = 1; g <= 3; g++) begin
      tick();
      wait_for($sformatf("step%0d_seen", g), 1, 200, n);
      check_eq($sformatf("step%0d_period", g), 64'(n + 1), 64'd27);
      check_eq($sformatf("step%0d_gen", g), 64'(generation), 64'(g));
    end

    // 4/5: seed_req mid-step; rogue stepper writes during the seed are dropped
    repeat (5) tick();
    rogue = 1'b1;
    seed_req = 1'b1;
    tick();
    seed_req = 1'b0;
    wait_for("midseed_seen", 0, 100, n);
    check_eq("midseed_delay", 64'(n + 6), 64'd22);
    check_eq("midseed_gen_step_done", 64'(generation), 64'd4);
    st = step_start_cnt;
    wait_for("postseed_step", 1, SEED_BUSY + 100, n);
    check_eq("postseed_gen", 64'(generation), 64'd0);
    check_eq("postseed_no_step_between", 64'(step_start_cnt - st), 64'd0);
    check_eq("rogue_owner", 64'(own_viol), 64'd0);
    check_arena("rogue");
    rogue = 1'b0;

    // 6: reset during STEP_WAIT
    tick();
    wait_for("pre_rst_step", 1, 200, n);
    repeat (6) tick();
    check_eq("pre_rst_gen", 64'(generation), 64'd1);
    check_eq("pre_rst_write", 64'(bus.arena_write), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_write", 64'(bus.arena_write), 64'd0);
    check_eq("async_rst_busy", 64'(busy), 64'd0);
    check_eq("async_rst_gen", 64'(generation), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;

    // 3: run with no seed since reset stays idle
    st = step_start_cnt;
    repeat (50) tick();
    check_eq("noseed_busy", 64'(busy), 64'd0);
    check_eq("noseed_no_step", 64'(step_start_cnt - st), 64'd0);

    run = 1'b0;
    seed_pass("seed2");

    // step_period 0 behaves as 1: period = 2 + 20 + 1
    run = 1'b1;
    step_period = '0;
    wait_for("p0_first", 1, 200, n);
    tick();
    wait_for("p0_second", 1, 200, n);
    check_eq("p0_period", 64'(n + 1), 64'd23);
    run = 1'b0;
    tick();
    wait_for("p0_idle", 2, 100, n);
    check_eq("p0_gen", 64'(generation), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
